dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter and sequencer that shares the single read/write port of the 64-word data memory between two requesters: the CPU load/store unit and the video readout engine. Both requesters reach the memory only through this block, which uses the memory's `a`/`WE`/`WD`/`Rd` port and leaves the dedicated video read port unused. Each requester gets a req/ack handshake with registered read data, and the arbiter alternates fairly under contention. An address outside the memory is rejected with an error instead of wrapping or aliasing.

## Interface
- `DEPTH`, 64: memory depth in 32-bit words; legal word indices are 0..DEPTH-1.
- `CLK`  in  1  system clock; all state changes on posedge.
- `RST`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; held until `cpu_ack`.
- `cpu_we`  in  1  1 = store, 0 = load; stable while `cpu_req` is high.
- `cpu_addr`  in  32  byte address; word index is `cpu_addr[31:2]`.
- `cpu_wd`  in  32  store data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rd`  out  32  load data, valid when `cpu_ack` = 1.
- `cpu_err`  out  1  valid with `cpu_ack`: the address was misaligned or out of range.
- `vid_req`  in  1  video read request; held until `vid_ack`.
- `vid_addr`  in  32  word index (not a byte address).
- `vid_ack`  out  1  one-cycle completion pulse.
- `vid_rd`  out  32  read data, valid when `vid_ack` = 1.
- `vid_err`  out  1  valid with `vid_ack`: the address was out of range.
- `mem_a`  out  32  byte address to the memory.
- `mem_we`  out  1  write enable to the memory.
- `mem_wd`  out  32  write data to the memory.
- `mem_rd`  in  32  asynchronous read data from the memory.

## Operation
- State register `state` takes one of three values: IDLE, GNT_CPU, GNT_VID.
- Next-state decision uses the request inputs in the current cycle, with the requester that holds the current grant masked out, because its request is still the one being served.
- From IDLE:
  - `cpu_req` → GNT_CPU.
  - Otherwise `vid_req` → GNT_VID.
  - Otherwise stay in IDLE.
- From GNT_CPU: `vid_req` → GNT_VID; otherwise → IDLE. CPU is never granted in two consecutive cycles.
- From GNT_VID: `cpu_req` → GNT_CPU; otherwise → IDLE.
- Memory drive, decoded combinationally from `state`:
  - GNT_CPU: `mem_a` = `cpu_addr`, `mem_wd` = `cpu_wd`, `mem_we` = `cpu_we` & ~bad_cpu.
  - GNT_VID: `mem_a` = {`vid_addr[29:0]`, 2'b00}, `mem_we` = 0.
  - IDLE: `mem_a` = 0, `mem_we` = 0.
- Bad addresses:
  - bad_cpu: `cpu_addr[1:0]` ≠ 0, or `cpu_addr[31:2]` ≥ DEPTH.
  - bad_vid: `vid_addr` ≥ DEPTH.
  - A bad access never writes the memory. It completes with `*_rd` = 0 and `*_err` = 1.
- Completion registers, updated at the end of each grant cycle:
  - Granted side: `*_ack` = 1 next cycle; `*_rd` = `mem_rd`, or 0 for a store or a bad address; `*_err` = bad flag.
  - Every ack is cleared after one cycle.
  - `*_rd` and `*_err` hold their value until the next completion on that side.
- A request that is still high in its own ack cycle counts as a new request and is eligible for arbitration in that cycle.

## Timing
- Uncontended latency: `req` high in cycle 0 → grant in cycle 1 → `ack` in cycle 2.
- Store commits at the posedge that ends the grant cycle.
- Both requesters continuously requesting: grants alternate CPU, VID, CPU, … with one access per cycle. Each side gets a throughput of 1 access per 2 cycles.
- Simultaneous requests from IDLE: CPU wins. Video is granted in the next cycle, so video latency is 3 cycles.
- A single requester issuing back-to-back requests gets one access per 2 cycles, because it is masked while it holds the grant.
- Reset values: `state` = IDLE; `cpu_ack`, `vid_ack`, `cpu_err`, `vid_err` = 0; `cpu_rd`, `vid_rd` = 0; `mem_we` = 0.
- Reset asserted during a grant cycle:
  - The access is aborted and no ack is issued. A store in that cycle is blocked (`mem_we` forced 0 while `RST` = 1).
  - Requesters must re-present the request after reset.
- Deasserting `req` before `ack` is illegal. Behavior is unspecified apart from the fact that no store occurs outside a grant cycle.

## Structure
- The shared header/package holds:
  - the state encodings: ST_IDLE = 2'd0, ST_GNT_CPU = 2'd1, ST_GNT_VID = 2'd2;
  - the default DEPTH.
- One sub-module: `dmem_addr_check` (combinational). Inputs: word index, alignment bits, DEPTH. Output: the bad flag. It is instantiated once per requester.
- The arbiter FSM, memory mux and completion registers stay in the top module.

## Test plan
- Reset, then CPU store to `cpu_addr` = 0x10 with `cpu_wd` = 0xDEADBEEF:
  - `mem_we` = 1 for exactly one cycle, with `mem_a` = 0x10;
  - `cpu_ack` arrives 2 cycles after `req`, with `cpu_err` = 0.
- Video read of `vid_addr` = 4 after that store: `mem_a` = 0x10; `vid_ack` arrives 2 cycles after `req`, with `vid_rd` = 0xDEADBEEF.
- `cpu_req` and `vid_req` both raised from IDLE and held, re-raised after every ack: grant sequence CPU, VID, CPU, VID; 4 acks within 5 cycles after the first grant.
- CPU store to 0x102 (misaligned), then 0x100 (word 64): `mem_we` stays 0; `cpu_ack` = 1, `cpu_err` = 1, `cpu_rd` = 0; memory contents unchanged.
- Video read at `vid_addr` = 64: `vid_err` = 1 and `vid_rd` = 0; a following read at index 63 returns the stored word with `vid_err` = 0.
- `RST` asserted during a GNT_CPU store cycle:
  - no write occurs and no `cpu_ack` is issued;
  - all outputs are 0 in the cycle after reset;
  - a re-issued request completes normally.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter: arbiter state encodings
//   and the default memory depth in 32-bit words.
package dmem_arbiter_pkg;

   localparam int DEPTH_DEFAULT = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GNT_CPU = 2'd1,
      ST_GNT_VID = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_addr_check.sv
// dmem_addr_check
//   Combinational legality check for one requester's memory access.
//   Ports:
//     word_idx  in  32  word index of the access
//     align     in  2   low byte-address bits (tie to 0 for word-addressed users)
//     bad       out 1   access is misaligned or beyond DEPTH-1
module dmem_addr_check
   import dmem_arbiter_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic [31:0] word_idx,
   input  logic [1:0]  align,
   output logic        bad
);

   assign bad = (align != 2'b00) || (word_idx >= 32'(DEPTH));

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single read/write port of the data memory between the CPU
//   load/store unit and the video readout engine. Each side uses a req/ack
//   handshake with registered read data; under contention the grant
//   alternates. Out-of-range or misaligned accesses complete with err=1,
//   rd=0 and never write the memory.
//   Ports:
//     CLK, RST                          clock, synchronous active-high reset
//     cpu_req/we/addr/wd                CPU request (byte address)
//     cpu_ack/rd/err                    CPU completion (registered)
//     vid_req/addr                      video read request (word index)
//     vid_ack/rd/err                    video completion (registered)
//     mem_a/we/wd, mem_rd               shared memory port (async read)
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wd,
   output logic        cpu_ack,
   output logic [31:0] cpu_rd,
   output logic        cpu_err,
   input  logic        vid_req,
   input  logic [31:0] vid_addr,
   output logic        vid_ack,
   output logic [31:0] vid_rd,
   output logic        vid_err,
   output logic [31:0] mem_a,
   output logic        mem_we,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   state_t state;
   logic   bad_cpu;
   logic   bad_vid;

   dmem_addr_check #(.DEPTH(DEPTH)) u_chk_cpu (
      .word_idx ({2'b00, cpu_addr[31:2]}),
      .align    (cpu_addr[1:0]),
      .bad      (bad_cpu)
   );

   dmem_addr_check #(.DEPTH(DEPTH)) u_chk_vid (
      .word_idx (vid_addr),
      .align    (2'b00),
      .bad      (bad_vid)
   );

   // Memory port is a pure decode of the grant state. The write enable is
   // gated by RST so a store caught by reset in its grant cycle is dropped.
   always_comb begin
      mem_a  = 32'd0;
      mem_wd = 32'd0;
      mem_we = 1'b0;
      case (state)
         ST_GNT_CPU: begin
            mem_a  = cpu_addr;
            mem_wd = cpu_wd;
            mem_we = cpu_we & ~bad_cpu & ~RST;
         end
         ST_GNT_VID: begin
            mem_a  = {vid_addr[29:0], 2'b00};
         end
         default: ;
      endcase
   end

   // Arbiter FSM plus completion registers. The side holding the grant is
   // masked from the next decision, which gives alternation under contention
   // and one access per two cycles for a lone back-to-back requester.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_IDLE;
         cpu_ack <= 1'b0;
         cpu_rd  <= 32'd0;
         cpu_err <= 1'b0;
         vid_ack <= 1'b0;
         vid_rd  <= 32'd0;
         vid_err <= 1'b0;
      end else begin
         cpu_ack <= 1'b0;
         vid_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cpu_req)      state <= ST_GNT_CPU;
               else if (vid_req) state <= ST_GNT_VID;
            end
            ST_GNT_CPU: begin
               cpu_ack <= 1'b1;
               cpu_rd  <= (cpu_we || bad_cpu) ? 32'd0 : mem_rd;
               cpu_err <= bad_cpu;
               state   <= vid_req ? ST_GNT_VID : ST_IDLE;
            end
            ST_GNT_VID: begin
               vid_ack <= 1'b1;
               vid_rd  <= bad_vid ? 32'd0 : mem_rd;
               vid_err <= bad_vid;
               state   <= cpu_req ? ST_GNT_CPU : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a behavioural 64-word memory.
//   Inputs change and outputs are sampled on the falling edge.
module tb_dmem_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wd;
   logic        cpu_ack, cpu_err;
   logic [31:0] cpu_rd;
   logic        vid_req;
   logic [31:0] vid_addr;
   logic        vid_ack, vid_err;
   logic [31:0] vid_rd;
   logic [31:0] mem_a, mem_wd, mem_rd;
   logic        mem_we;

   logic [31:0] tb_mem [0:63];
   logic        mem_load;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   dmem_arbiter dut (
      .CLK(CLK), .RST(RST),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
      .cpu_ack(cpu_ack), .cpu_rd(cpu_rd), .cpu_err(cpu_err),
      .vid_req(vid_req), .vid_addr(vid_addr),
      .vid_ack(vid_ack), .vid_rd(vid_rd), .vid_err(vid_err),
      .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   // Memory model: async read, write on posedge; preloaded with A500_00ii.
   assign mem_rd = tb_mem[mem_a[7:2]];
   always @(posedge CLK) begin
      if (mem_load) begin
         for (int i = 0; i < 64; i++) tb_mem[i] <= 32'hA500_0000 | 32'(i);
      end else if (mem_we) begin
         tb_mem[mem_a[7:2]] <= mem_wd;
      end
   end

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RST = 1'b1; mem_load = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wd = 0;
      vid_req = 0; vid_addr = 0;
      tick(); tick();
      mem_load = 1'b0;
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack: got %b expected 0", cpu_ack); end
      checks++; if (vid_ack !== 1'b0) begin errors++; $display("FAIL reset_vid_ack: got %b expected 0", vid_ack); end
      checks++; if ({cpu_err, vid_err} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {cpu_err, vid_err}); end
      checks++; if (cpu_rd !== 32'd0 || vid_rd !== 32'd0) begin errors++; $display("FAIL reset_rd: got %h/%h expected 0/0", cpu_rd, vid_rd); end
      checks++; if (mem_we !== 1'b0 || mem_a !== 32'd0) begin errors++; $display("FAIL reset_mem: got we=%b a=%h expected 0/0", mem_we, mem_a); end
      RST = 1'b0;
      tick();
   endtask

   task automatic test_cpu_store();
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wd = 32'hDEADBEEF;
      tick();
      checks++; if (mem_we !== 1'b1 || mem_a !== 32'h10) begin errors++; $display("FAIL store_grant: got we=%b a=%h expected 1/00000010", mem_we, mem_a); end
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL store_early_ack: got %b expected 0", cpu_ack); end
      tick();
      checks++; if (cpu_ack !== 1'b1 || cpu_err !== 1'b0) begin errors++; $display("FAIL store_ack: got ack=%b err=%b expected 1/0", cpu_ack, cpu_err); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL store_we_once: got %b expected 0", mem_we); end
      cpu_req = 0; cpu_we = 0;
      tick();
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL store_ack_pulse: got %b expected 0", cpu_ack); end
      checks++; if (tb_mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL store_mem: got %h expected deadbeef", tb_mem[4]); end
   endtask

   task automatic test_vid_read();
      vid_req = 1; vid_addr = 32'd4;
      tick();
      checks++; if (mem_a !== 32'h10 || mem_we !== 1'b0) begin errors++; $display("FAIL vid_grant: got a=%h we=%b expected 00000010/0", mem_a, mem_we); end
      tick();
      checks++; if (vid_ack !== 1'b1 || vid_rd !== 32'hDEADBEEF || vid_err !== 1'b0) begin errors++; $display("FAIL vid_ack: got ack=%b rd=%h err=%b expected 1/deadbeef/0", vid_ack, vid_rd, vid_err); end
      vid_req = 0;
      tick();
      checks++; if (vid_ack !== 1'b0) begin errors++; $display("FAIL vid_ack_pulse: got %b expected 0", vid_ack); end
   endtask

   task automatic test_contention();
      logic [31:0] exp_a [1:5];
      int acks;
      exp_a[1] = 32'h20; exp_a[2] = 32'h14; exp_a[3] = 32'h20; exp_a[4] = 32'h14; exp_a[5] = 32'h0;
      acks = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20; vid_req = 1; vid_addr = 32'd5;
      for (int c = 1; c <= 5; c++) begin
         tick();
         checks++; if (mem_a !== exp_a[c]) begin errors++; $display("FAIL contend_grant_c%0d: got a=%h expected %h", c, mem_a, exp_a[c]); end
         acks += int'(cpu_ack) + int'(vid_ack);
         if (c == 2) begin
            checks++; if (cpu_ack !== 1'b1 || cpu_rd !== 32'hA500_0008) begin errors++; $display("FAIL contend_cpu_rd: got ack=%b rd=%h expected 1/a5000008", cpu_ack, cpu_rd); end
         end
         if (c == 3) begin
            checks++; if (vid_ack !== 1'b1 || vid_rd !== 32'hA500_0005) begin errors++; $display("FAIL contend_vid_rd: got ack=%b rd=%h expected 1/a5000005", vid_ack, vid_rd); end
         end
         if (c == 4) cpu_req = 0;
         if (c == 5) vid_req = 0;
      end
      checks++; if (acks !== 4) begin errors++; $display("FAIL contend_ack_count: got %0d expected 4", acks); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_a [1:4];
      exp_a[1] = 32'h24; exp_a[2] = 32'h0; exp_a[3] = 32'h24; exp_a[4] = 32'h0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h24;
      for (int c = 1; c <= 4; c++) begin
         tick();
         checks++; if (mem_a !== exp_a[c] || cpu_ack !== logic'(c % 2 == 0)) begin errors++; $display("FAIL b2b_c%0d: got a=%h ack=%b expected %h/%0d", c, mem_a, cpu_ack, exp_a[c], c % 2 == 0); end
      end
      checks++; if (cpu_rd !== 32'hA500_0009) begin errors++; $display("FAIL b2b_rd: got %h expected a5000009", cpu_rd); end
      cpu_req = 0;
      tick();
   endtask

   task automatic test_bad_cpu();
      logic [31:0] addrs [0:1];
      addrs[0] = 32'h102; addrs[1] = 32'h100;
      for (int k = 0; k < 2; k++) begin
         cpu_req = 1; cpu_we = 1; cpu_addr = addrs[k]; cpu_wd = 32'h12345678;
         tick();
         checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL bad_cpu_we_%h: got %b expected 0", addrs[k], mem_we); end
         tick();
         checks++; if (cpu_ack !== 1'b1 || cpu_err !== 1'b1 || cpu_rd !== 32'd0) begin errors++; $display("FAIL bad_cpu_ack_%h: got ack=%b err=%b rd=%h expected 1/1/0", addrs[k], cpu_ack, cpu_err, cpu_rd); end
         cpu_req = 0; cpu_we = 0;
         tick();
      end
      checks++; if (tb_mem[0] !== 32'hA500_0000) begin errors++; $display("FAIL bad_cpu_mem: got %h expected a5000000", tb_mem[0]); end
   endtask

   task automatic test_bad_vid();
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'hFC; cpu_wd = 32'hCAFEF00D;
      tick();
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL w63_we: got %b expected 1", mem_we); end
      tick();
      cpu_req = 0; cpu_we = 0;
      tick();
      vid_req = 1; vid_addr = 32'd64;
      tick();
      checks++; if (mem_a !== 32'h100 || mem_we !== 1'b0) begin errors++; $display("FAIL bad_vid_grant: got a=%h we=%b expected 00000100/0", mem_a, mem_we); end
      tick();
      checks++; if (vid_ack !== 1'b1 || vid_err !== 1'b1 || vid_rd !== 32'd0) begin errors++; $display("FAIL bad_vid_ack: got ack=%b err=%b rd=%h expected 1/1/0", vid_ack, vid_err, vid_rd); end
      vid_req = 0;
      tick();
      vid_req = 1; vid_addr = 32'd63;
      tick(); tick();
      checks++; if (vid_ack !== 1'b1 || vid_err !== 1'b0 || vid_rd !== 32'hCAFEF00D) begin errors++; $display("FAIL vid63: got ack=%b err=%b rd=%h expected 1/0/cafef00d", vid_ack, vid_err, vid_rd); end
      vid_req = 0;
      tick();
   endtask

   task automatic test_reset_abort();
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wd = 32'h11112222;
      tick();
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL abort_pre_we: got %b expected 1", mem_we); end
      RST = 1'b1; cpu_req = 0; cpu_we = 0;
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_we_gated: got %b expected 0", mem_we); end
      tick();
      checks++; if ({cpu_ack, vid_ack, cpu_err, vid_err, mem_we} !== 5'b0 || cpu_rd !== 32'd0 || vid_rd !== 32'd0 || mem_a !== 32'd0)
         begin errors++; $display("FAIL abort_outputs: got ack=%b%b err=%b%b we=%b rd=%h/%h a=%h expected all 0", cpu_ack, vid_ack, cpu_err, vid_err, mem_we, cpu_rd, vid_rd, mem_a); end
      checks++; if (tb_mem[8] !== 32'hA500_0008) begin errors++; $display("FAIL abort_mem: got %h expected a5000008", tb_mem[8]); end
      RST = 1'b0;
      tick();
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL abort_no_ack: got %b expected 0", cpu_ack); end
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wd = 32'h11112222;
      tick();
      checks++; if (mem_we !== 1'b1 || mem_a !== 32'h20) begin errors++; $display("FAIL reissue_grant: got we=%b a=%h expected 1/00000020", mem_we, mem_a); end
      tick();
      checks++; if (cpu_ack !== 1'b1 || cpu_err !== 1'b0) begin errors++; $display("FAIL reissue_ack: got ack=%b err=%b expected 1/0", cpu_ack, cpu_err); end
      cpu_req = 0; cpu_we = 0;
      tick();
      checks++; if (tb_mem[8] !== 32'h11112222) begin errors++; $display("FAIL reissue_mem: got %h expected 11112222", tb_mem[8]); end
   endtask

   initial begin
      test_reset();
      test_cpu_store();
      test_vid_read();
      test_contention();
      test_back_to_back();
      test_bad_cpu();
      test_bad_vid();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
